// File: rtl/addr_bus_arbiter.sv
// ---------------------------------------------------------------------------
// addr_bus_arbiter
//
// Shares one addressed peripheral bus among NUM_REQ requesters. A round-robin
// arbiter picks one requester per transaction, drives its address, direction
// and write data onto the shared bus, and waits for the peripheral ack. If no
// ack arrives within TIMEOUT cycles, the transfer is aborted with an error.
// Each transaction takes the sequence IDLE -> ACCESS -> DONE. All outputs
// are registered.
//
// Ports
//   clk               system clock, rising edge
//   rst_n             asynchronous active-low reset
//   req               per-requester request level
//   req_write         per-requester direction (1 = write, 0 = read)
//   req_addr          per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata         per-requester write data, same packing with DATA_W
//   gnt               one-hot grant of the requester being served (ACCESS)
//   done              one-hot single-cycle completion pulse (DONE)
//   rsp_rdata         read data of the last completed transaction
//   rsp_err           1 when the last transaction timed out
//   bus_address       shared bus address
//   bus_read_enable   shared read enable
//   bus_write_enable  shared write enable
//   bus_wdata         shared write data
//   bus_rdata         read data returned by the addressed peripheral
//   bus_ack           peripheral completion strobe
// ---------------------------------------------------------------------------
module addr_bus_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic [ADDR_W-1:0]         bus_address,
   output logic                      bus_read_enable,
   output logic                      bus_write_enable,
   output logic [DATA_W-1:0]         bus_wdata,
   input  logic [DATA_W-1:0]         bus_rdata,
   input  logic                      bus_ack
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    last_grant_q, last_grant_d;
   logic [IDX_W-1:0]    sel_q, sel_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [NUM_REQ-1:0]  done_q, done_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic [ADDR_W-1:0]   bus_address_q, bus_address_d;
   logic                rd_en_q, rd_en_d;
   logic                wr_en_q, wr_en_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   // Round-robin pick: first requesting index scanning upward from the
   // requester after the last one served, wrapping modulo NUM_REQ.
   logic                arb_found;
   logic [IDX_W-1:0]    arb_idx;
   logic [IDX_W-1:0]    arb_cand;

   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         arb_cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
         if (!arb_found && req[arb_cand]) begin
            arb_found = 1'b1;
            arb_idx   = arb_cand;
         end
      end
   end

   // Next-state and registered-output logic.
   logic finish;

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      sel_d         = sel_q;
      cnt_d         = cnt_q;
      gnt_d         = gnt_q;
      done_d        = '0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      bus_address_d = bus_address_q;
      rd_en_d       = rd_en_q;
      wr_en_d       = wr_en_q;
      wdata_d       = wdata_q;
      finish        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               sel_d         = arb_idx;
               gnt_d         = NUM_REQ'(1) << arb_idx;
               bus_address_d = req_addr[arb_idx*ADDR_W +: ADDR_W];
               wdata_d       = req_wdata[arb_idx*DATA_W +: DATA_W];
               wr_en_d       = req_write[arb_idx];
               rd_en_d       = !req_write[arb_idx];
               cnt_d         = '0;
               state_d       = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            // Ack takes priority over an expiring timeout in the same cycle.
            if (bus_ack) begin
               rsp_rdata_d = wr_en_q ? '0 : bus_rdata;
               rsp_err_d   = 1'b0;
               finish      = 1'b1;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               finish      = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end

            if (finish) begin
               done_d        = gnt_q;
               gnt_d         = '0;
               bus_address_d = '0;
               wdata_d       = '0;
               rd_en_d       = 1'b0;
               wr_en_d       = 1'b0;
               state_d       = ST_DONE;
            end
         end

         ST_DONE: begin
            last_grant_d = sel_q;
            state_d      = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= IDX_W'(NUM_REQ - 1);
         sel_q         <= '0;
         cnt_q         <= '0;
         gnt_q         <= '0;
         done_q        <= '0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         bus_address_q <= '0;
         rd_en_q       <= 1'b0;
         wr_en_q       <= 1'b0;
         wdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         sel_q         <= sel_d;
         cnt_q         <= cnt_d;
         gnt_q         <= gnt_d;
         done_q        <= done_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         bus_address_q <= bus_address_d;
         rd_en_q       <= rd_en_d;
         wr_en_q       <= wr_en_d;
         wdata_q       <= wdata_d;
      end
   end

   assign gnt              = gnt_q;
   assign done             = done_q;
   assign rsp_rdata        = rsp_rdata_q;
   assign rsp_err          = rsp_err_q;
   assign bus_address      = bus_address_q;
   assign bus_read_enable  = rd_en_q;
   assign bus_write_enable = wr_en_q;
   assign bus_wdata        = wdata_q;

endmodule
